// File: rtl/point_loader.sv
// Writer side of the interpolation input memory: assembles big-endian (x, y) points
// from a byte stream, writes them to a dual-port BRAM and reports count and status.
module point_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wea,
    output logic [15:0]       mem_dina,
    output logic              mem_web,
    output logic [15:0]       mem_dinb,
    output logic [ADDR_W:0]   point_count,
    output logic              busy,
    output logic              done,
    output logic [1:0]        error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [1:0]      ERR_NONE = 2'd0;
    localparam logic [1:0]      ERR_MONO = 2'd1;
    localparam logic [1:0]      ERR_EMPTY = 2'd2;

    logic [2:0]        state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [15:0]       x_q, x_d;
    logic [15:0]       y_q, y_d;
    logic [15:0]       prev_x_q, prev_x_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic [1:0]        error_q, error_d;
    logic              accept;

    assign s_ready = (state_q == S_RECV) && !start;
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        x_d        = x_q;
        y_d        = y_q;
        prev_x_d   = prev_x_q;
        count_d    = count_q;
        done_d     = done_q;
        error_d    = error_q;

        if (start) begin
            // Restart from any state; partial frame bytes are simply forgotten.
            state_d    = S_RECV;
            byte_idx_d = 2'd0;
            count_d    = '0;
            done_d     = 1'b0;
            error_d    = ERR_NONE;
        end else begin
            case (state_q)
                S_RECV: begin
                    if (accept) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: x_d[15:8] = s_data;
                            2'd1: x_d[7:0]  = s_data;
                            2'd2: y_d[15:8] = s_data;
                            2'd3: begin
                                y_d[7:0] = s_data;
                                // x is complete once byte 1 has been taken, so x_q is final here.
                                if (x_q == 16'hFFFF) begin
                                    if (count_q == '0) begin
                                        state_d = S_ERR;
                                        error_d = ERR_EMPTY;
                                    end else begin
                                        state_d = S_DONE;
                                        done_d  = 1'b1;
                                    end
                                end else if ((count_q != '0) && (x_q <= prev_x_q)) begin
                                    state_d = S_ERR;
                                    error_d = ERR_MONO;
                                end else begin
                                    state_d = S_WRITE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_WRITE: begin
                    prev_x_d = x_q;
                    count_d  = count_q + 1'b1;
                    if (count_d == DEPTH_C) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RECV;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            byte_idx_q <= 2'd0;
            x_q        <= '0;
            y_q        <= '0;
            prev_x_q   <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            x_q        <= x_d;
            y_q        <= y_d;
            prev_x_q   <= prev_x_d;
            count_q    <= count_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // The write address is the count before the WRITE-cycle increment.
    assign mem_addr    = count_q[ADDR_W-1:0];
    assign mem_dina    = x_q;
    assign mem_dinb    = y_q;
    assign mem_wea     = (state_q == S_WRITE);
    assign mem_web     = (state_q == S_WRITE);
    assign point_count = count_q;
    assign busy        = (state_q == S_RECV) || (state_q == S_WRITE);
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_point_loader.sv
// Scoreboard bench for point_loader: stimulus queues expected writes, a monitor
// pops and checks every write pulse; status is checked after each load.
module tb_point_loader;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wea;
    logic [15:0]       mem_dina;
    logic              mem_web;
    logic [15:0]       mem_dinb;
    logic [ADDR_W:0]   point_count;
    logic              busy;
    logic              done;
    logic [1:0]        error;

    point_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mem_addr(mem_addr), .mem_wea(mem_wea), .mem_dina(mem_dina),
        .mem_web(mem_web), .mem_dinb(mem_dinb),
        .point_count(point_count), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       a;
        logic [15:0]       b;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // Monitor: every write pulse must match the head of the expected queue.
    logic prev_we = 1'b0;
    always @(negedge clk) begin
        if (mem_wea !== mem_web) chk("wea_eq_web", int'(mem_wea), int'(mem_web));
        if (mem_wea) begin
            if (prev_we) chk("we_pulse_len", 2, 1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr=%0d a=%0d b=%0d, expected no write",
                         mem_addr, mem_dina, mem_dinb);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                n_checks++;
                if (mem_addr !== e.addr || mem_dina !== e.a || mem_dinb !== e.b) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0d a=%0d b=%0d, expected addr=%0d a=%0d b=%0d",
                             mem_addr, mem_dina, mem_dinb, e.addr, e.a, e.b);
                end else begin
                    $display("ok   write addr=%0d a=%0d b=%0d", mem_addr, mem_dina, mem_dinb);
                end
            end
        end
        prev_we = mem_wea;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic try_byte(input logic [7:0] b, input int budget, output bit acc);
        s_data  = b;
        s_valid = 1'b1;
        acc     = 1'b0;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk);
            acc = s_ready;
            step();
        end
        s_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        repeat (gap) step();
        try_byte(b, 50, acc);
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_accept: byte %0h not accepted within budget, expected accepted", b);
        end
    endtask

    task automatic send_point(input logic [15:0] x, input logic [15:0] y, input int gap_max);
        send_byte(x[15:8], $urandom_range(0, gap_max));
        send_byte(x[7:0],  $urandom_range(0, gap_max));
        send_byte(y[15:8], $urandom_range(0, gap_max));
        send_byte(y[7:0],  $urandom_range(0, gap_max));
    endtask

    task automatic expect_write(input int addr, input int a, input int b);
        wr_t e;
        e.addr = addr[ADDR_W-1:0];
        e.a    = a[15:0];
        e.b    = b[15:0];
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_status(input string tag, input int d, input int err, input int cnt);
        @(negedge clk);
        chk({tag, ".done"}, int'(done), d);
        chk({tag, ".error"}, int'(error), err);
        chk({tag, ".count"}, int'(point_count), cnt);
        chk({tag, ".busy"}, int'(busy), 0);
        chk({tag, ".s_ready"}, int'(s_ready), 0);
        step();
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        chk({tag, ".s_ready"}, int'(s_ready), 0);
        chk({tag, ".busy"}, int'(busy), 0);
        chk({tag, ".done"}, int'(done), 0);
        chk({tag, ".error"}, int'(error), 0);
        chk({tag, ".count"}, int'(point_count), 0);
        chk({tag, ".addr"}, int'(mem_addr), 0);
        chk({tag, ".dina"}, int'(mem_dina), 0);
        chk({tag, ".dinb"}, int'(mem_dinb), 0);
        chk({tag, ".wea"}, int'(mem_wea), 0);
        step();
    endtask

    initial begin
        bit acc;
        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) step();
        reset = 1'b0;
        check_reset_vals("reset");

        // Normal load
        pulse_start();
        expect_write(0, 10, 100);
        expect_write(1, 20, 300);
        expect_write(2, 35, 50);
        send_point(16'd10, 16'd100, 0);
        send_point(16'd20, 16'd300, 0);
        send_point(16'd35, 16'd50, 0);
        send_point(16'hFFFF, 16'd0, 0);
        check_status("normal", 1, 0, 3);
        chk("normal.pending", exp_q.size(), 0);

        // Non-monotonic x
        pulse_start();
        expect_write(0, 10, 1);
        expect_write(1, 20, 2);
        send_point(16'd10, 16'd1, 0);
        send_point(16'd20, 16'd2, 0);
        send_point(16'd20, 16'd3, 0);
        check_status("nonmono", 0, 1, 2);

        // Empty load
        pulse_start();
        send_point(16'hFFFF, 16'h1234, 0);
        check_status("empty", 0, 2, 0);

        // Full at DEPTH points
        pulse_start();
        for (int i = 0; i < DEPTH; i++) expect_write(i, i + 1, 16 * (i + 1));
        for (int i = 0; i < DEPTH; i++) send_point(16'(i + 1), 16'(16 * (i + 1)), 0);
        step();
        check_status("full", 1, 0, DEPTH);
        try_byte(8'h00, 8, acc);
        chk("full.5th_byte_accepted", int'(acc), 0);
        chk("full.pending", exp_q.size(), 0);

        // Restart mid-frame, with s_valid in the same cycle as start
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h09, 0);
        start   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hAA;
        @(negedge clk);
        chk("restart.s_ready_with_start", int'(s_ready), 0);
        step();
        start   = 1'b0;
        s_valid = 1'b0;
        expect_write(0, 5, 7);
        send_point(16'd5, 16'd7, 0);
        send_point(16'hFFFF, 16'd0, 0);
        check_status("restart", 1, 0, 1);

        // Reset mid-frame: the byte completing the point arrives with reset high
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h40, 0);
        send_byte(8'h00, 0);
        reset   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h01;
        step();
        reset   = 1'b0;
        s_valid = 1'b0;
        check_reset_vals("midreset");
        step();

        // Backpressure: random s_valid gaps
        pulse_start();
        expect_write(0, 10, 100);
        expect_write(1, 20, 300);
        expect_write(2, 35, 50);
        send_point(16'd10, 16'd100, 3);
        send_point(16'd20, 16'd300, 3);
        send_point(16'd35, 16'd50, 3);
        send_point(16'hFFFF, 16'd0, 3);
        check_status("backpressure", 1, 0, 3);

        repeat (3) step();
        chk("final.pending", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
